// File: rtl/gpr_file_param.sv
// Register file: 1 write port, 2 combinational read ports, and a sequential clear engine that sweeps one entry per cycle.
// Optional write-to-read forwarding is enabled when the GPR_BYPASS_EN macro is defined.
module gpr_file_param #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 3,
    parameter int ZERO_REG0 = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              reg_write_en,
    input  logic [ADDR_W-1:0] reg_write_dest,
    input  logic [DATA_W-1:0] reg_write_data,
    input  logic [ADDR_W-1:0] reg_read_addr1,
    output logic [DATA_W-1:0] reg_read_data1,
    input  logic [ADDR_W-1:0] reg_read_addr2,
    output logic [DATA_W-1:0] reg_read_data2,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic [DATA_W-1:0] regs [DEPTH];
    logic              wr_ok;

    // Writes to a hard-wired zero register are dropped here, which also keeps them out of the forwarding path.
    assign wr_ok = reg_write_en && !clr_busy &&
                   !((ZERO_REG0 != 0) && (reg_write_dest == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            clr_busy <= 1'b0;
            clr_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    clr_done <= 1'b0;
                    if (clr_req) begin
                        state    <= CLEAR;
                        clr_busy <= 1'b1;
                        cnt      <= '0;
                    end
                end
                CLEAR: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == ADDR_W'(DEPTH - 1)) begin
                        state    <= DONE;
                        clr_busy <= 1'b0;
                        clr_done <= 1'b1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    clr_done <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    clr_busy <= 1'b0;
                    clr_done <= 1'b0;
                end
            endcase
        end
    end

    // clr_busy is high exactly while the FSM is in CLEAR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (clr_busy) begin
            regs[cnt] <= '0;
        end else if (wr_ok) begin
            regs[reg_write_dest] <= reg_write_data;
        end
    end

    always_comb begin
        reg_read_data1 = regs[reg_read_addr1];
        reg_read_data2 = regs[reg_read_addr2];
`ifdef GPR_BYPASS_EN
        if (wr_ok && (reg_write_dest == reg_read_addr1)) begin
            reg_read_data1 = reg_write_data;
        end
        if (wr_ok && (reg_write_dest == reg_read_addr2)) begin
            reg_read_data2 = reg_write_data;
        end
`endif
        if ((ZERO_REG0 != 0) && (reg_read_addr1 == '0)) begin
            reg_read_data1 = '0;
        end
        if ((ZERO_REG0 != 0) && (reg_read_addr2 == '0)) begin
            reg_read_data2 = '0;
        end
    end
endmodule
